// File: rtl/deaccumulator_pkg.sv
// rtl/deaccumulator_pkg.sv - shared width default and state encoding for the deaccumulator
package deaccumulator_pkg;

  localparam int BITWIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/deaccumulator.sv
// rtl/deaccumulator.sv - drains a loaded total as a stream of step-bounded increments
module deaccumulator
  import deaccumulator_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEFAULT
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iClr,
  input  logic                iLoad,
  input  logic [BITWIDTH:0]   iTotal,
  input  logic [BITWIDTH-1:0] iStep,
  output logic [BITWIDTH-1:0] oData,
  output logic                oValid,
  input  logic                iReady,
  output logic                oLast,
  output logic                oBusy,
  output logic                oDone
);

  state_e              state_q, state_d;
  logic [BITWIDTH:0]   rem_q, rem_d;
  logic [BITWIDTH-1:0] step_q, step_d;

  logic                rem_le_step;
  logic [BITWIDTH-1:0] chunk;
  logic                emit;

  // When rem fits within one step it is known to be narrower than BITWIDTH+1 bits.
  assign rem_le_step = (rem_q <= {1'b0, step_q});
  assign chunk       = rem_le_step ? rem_q[BITWIDTH-1:0] : step_q;
  assign emit        = (state_q == ST_EMIT);

  assign oValid = emit;
  assign oData  = emit ? chunk : '0;
  assign oLast  = emit & rem_le_step;
  assign oBusy  = (state_q == ST_EMIT) | (state_q == ST_DONE);
  assign oDone  = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    step_d  = step_q;
    if (iClr) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      step_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iLoad) begin
            rem_d   = iTotal;
            step_d  = (iStep == '0) ? '1 : iStep;
            state_d = (iTotal == '0) ? ST_DONE : ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (iReady) begin
            rem_d = rem_q - {1'b0, chunk};
            if (rem_le_step) state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: tb/tb_deaccumulator.sv
// tb/tb_deaccumulator.sv - randomized self-checking bench against a beat-queue reference model
module tb_deaccumulator;

  localparam int BW = 8;

  logic          iClk = 1'b0;
  logic          iRstN;
  logic          iClr;
  logic          iLoad;
  logic [BW:0]   iTotal;
  logic [BW-1:0] iStep;
  logic [BW-1:0] oData;
  logic          oValid;
  logic          iReady;
  logic          oLast;
  logic          oBusy;
  logic          oDone;

  int n_tests = 0;
  int n_fail  = 0;

  deaccumulator #(.BITWIDTH(BW)) dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iClr   (iClr),
    .iLoad  (iLoad),
    .iTotal (iTotal),
    .iStep  (iStep),
    .oData  (oData),
    .oValid (oValid),
    .iReady (iReady),
    .oLast  (oLast),
    .oBusy  (oBusy),
    .oDone  (oDone)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, oValid, 0);
    check({tag, "_data"},  oData,  0);
    check({tag, "_last"},  oLast,  0);
    check({tag, "_busy"},  oBusy,  0);
    check({tag, "_done"},  oDone,  0);
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low for the first two cycles
  task automatic run_txn(input int total, input int step, input int mode);
    int beats[$];
    int eff;
    int r;
    int sum;
    int cyc;
    logic rdy;
    eff = (step == 0) ? (1 << BW) - 1 : step;
    r = total;
    while (r > 0) begin
      beats.push_back((r < eff) ? r : eff);
      r -= (r < eff) ? r : eff;
    end
    sum = 0;
    cyc = 0;
    @(negedge iClk);
    check("idle_before_load", oBusy, 0);
    iLoad  = 1'b1;
    iTotal = total[BW:0];
    iStep  = step[BW-1:0];
    @(negedge iClk);
    iLoad  = 1'b0;
    iTotal = $urandom;
    iStep  = $urandom;
    while (beats.size() > 0) begin
      if (cyc > 5000) begin
        check("drain_timeout", 0, 1);
        break;
      end
      check("beat_valid", oValid, 1);
      check("beat_data",  oData,  beats[0]);
      check("beat_last",  oLast,  beats.size() == 1);
      check("beat_busy",  oBusy,  1);
      check("beat_done",  oDone,  0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = $urandom_range(0, 1) == 1;
        default: rdy = (cyc >= 2);
      endcase
      iReady = rdy;
      iLoad  = ($urandom_range(0, 7) == 0);
      iTotal = $urandom;
      iStep  = $urandom;
      if (rdy) begin
        sum += beats[0];
        void'(beats.pop_front());
      end
      cyc++;
      @(negedge iClk);
    end
    iLoad  = 1'b0;
    iReady = $urandom_range(0, 1) == 1;
    check("done_pulse", oDone,  1);
    check("done_valid", oValid, 0);
    check("done_busy",  oBusy,  1);
    check("sum_equals_total", sum, total);
    @(negedge iClk);
    check("after_done", oDone, 0);
    check("after_busy", oBusy, 0);
  endtask

  initial begin
    iRstN  = 1'b0;
    iClr   = 1'b0;
    iLoad  = 1'b0;
    iTotal = '0;
    iStep  = '0;
    iReady = 1'b0;
    #12;
    check_quiet("reset");
    @(negedge iClk);
    iRstN = 1'b1;

    run_txn(10, 4, 0);
    run_txn(9, 4, 2);
    run_txn(0, 3, 1);
    run_txn(511, 0, 0);
    run_txn(255, 255, 0);
    run_txn(511, 1, 0);

    // abort with iClr while the consumer is ready
    @(negedge iClk);
    iLoad = 1'b1; iTotal = 20; iStep = 5;
    @(negedge iClk);
    iLoad = 1'b0; iReady = 1'b1;
    check("clr_first_beat", oData, 5);
    @(negedge iClk);
    iClr = 1'b1;
    @(negedge iClk);
    iClr = 1'b0; iReady = 1'b0;
    check_quiet("after_clr");
    @(negedge iClk);
    check("clr_no_done", oDone, 0);
    run_txn(3, 2, 1);

    // asynchronous reset mid-stream
    @(negedge iClk);
    iLoad = 1'b1; iTotal = 100; iStep = 7;
    @(negedge iClk);
    iLoad = 1'b0; iReady = 1'b1;
    @(posedge iClk);
    #2 iRstN = 1'b0;
    #1 check_quiet("async_reset");
    #14 iRstN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      check_quiet("post_reset_idle");
    end
    iReady = 1'b0;

    for (int t = 0; t < 30; t++)
      run_txn($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/deaccumulator.md
Name: deaccumulator

Overview:
Inverse of the accumulator block. It loads a (BITWIDTH+1)-bit accumulated total and drains it as a stream of BITWIDTH-bit increments under a valid/ready handshake, using chunks no larger than a programmable step. The emitted increments sum to exactly the loaded total. Feeding each accepted beat into an accumulator (iEn = oValid & iReady) reconstructs the original total. It sits upstream of accumulators and unary datapaths that consume per-cycle increments.

Parameters:
BITWIDTH, 8 (from the shared `BITWIDTH define), width of one increment; the total is BITWIDTH+1 bits.

Ports:
iClk  input  1  clock, rising edge.
iRstN  input  1  reset, asynchronous, active-low.
iClr  input  1  synchronous abort/clear.
iLoad  input  1  start request; sampled only in IDLE.
iTotal  input  BITWIDTH+1  total to drain.
iStep  input  BITWIDTH  maximum chunk per beat; 0 means all-ones (2^BITWIDTH-1).
oData  output  BITWIDTH  current increment.
oValid  output  1  oData valid.
iReady  input  1  consumer accepts the beat.
oLast  output  1  current beat is the final one.
oBusy  output  1  high in EMIT and DONE.
oDone  output  1  one-cycle completion pulse.

Behaviour:
- Registers: state, rem[BITWIDTH:0], step[BITWIDTH-1:0].
- Async reset (iRstN=0): state=IDLE, rem=0, step=0. All outputs are 0 while reset is asserted, including mid-stream. No oDone is generated.
- Outputs depend only on registered state. There is no combinational path from any input to any output.
- oData = min(rem, step) in EMIT, otherwise 0. oValid = (state==EMIT). oLast = oValid & (rem <= step). oDone = (state==DONE).
- Priority, highest first: reset, iClr, then FSM.
- iClr=1: next state=IDLE, rem=0, step=0. No oDone. The beat in flight is dropped even if iReady=1 in the same cycle.
- IDLE:
  - iLoad=1: rem <= iTotal; step <= (iStep==0 ? all-ones : iStep).
  - Next state is DONE if iTotal==0, else EMIT.
  - First oValid appears the cycle after iLoad (latency 1).
- EMIT:
  - Handshake = oValid & iReady. On handshake, rem <= rem - oData.
  - If oLast is also set, next state is DONE. Otherwise stay in EMIT.
  - No handshake: all registers hold, and oData/oLast stay stable.
  - oValid never drops without a handshake, except on iClr or reset.
- DONE: oDone=1 for exactly one cycle, then IDLE. A new iLoad is accepted at the earliest in the IDLE cycle after DONE.
- iLoad outside IDLE is ignored, with no side effects. iTotal/iStep changes outside IDLE have no effect.
- Widths: subtraction is BITWIDTH+1 bits and never underflows, because oData <= rem.
- Beat count = ceil(total/step). Worst case is step=1 with total=2^(BITWIDTH+1)-1.
- Invariant: sum of accepted oData equals iTotal. Every beat except the last equals step. The last beat is in 1..step.

Decomposition:
- Shared def file (deaccumulator.def, included like accumulator.def) holds:
  - the `BITWIDTH default;
  - state encodings: IDLE=2'd0, EMIT=2'd1, DONE=2'd2.
- No RTL sub-module is needed; the min/compare is inline.
- The bench instantiates the existing accumulator as the reconstruction scoreboard.

Test Plan:
1. BITWIDTH=8; iLoad, total=10, step=4, iReady=1 -> oValid on cycles 1-3. oData 4,4,2, oLast only on the 2. oDone on cycle 4. Scoreboard accumulator reads 10.
2. total=9, step=4, iReady low for 2 cycles on the first beat -> oData holds 4 with oValid=1 and no rem change. Beats then run 4,4,1, with oLast on the 1.
3. total=0, iLoad -> no oValid ever. oDone pulses on cycle 1. IDLE on cycle 2.
4. total=511, step=0 -> beats 255,255,1, oLast on the 1. Accumulator reconstructs 511. Also total=255, step=255 -> single beat 255 with oLast=1.
5. total=20, step=5; after the first handshake, assert iClr together with iReady=1 -> next cycle oValid=0, oBusy=0, no oDone, rem=0. A later iLoad of 3/2 gives beats 2,1. An iLoad pulsed mid-stream is ignored.
6. Drop iRstN asynchronously mid-EMIT (not on a clock edge) -> all outputs 0 immediately. After release the block stays IDLE until iLoad, and no oDone is emitted.
